// File: rtl/eth_link_reset_seq.sv
// eth_link_reset_seq: per-channel link status sync, debounce and MAC reset
// sequencing with sw reset, hold-while-down mode and link-change counters.
module eth_link_reset_seq #(
  parameter int NUM_CH          = 4,
  parameter int SYNC_STAGES     = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 8,
  parameter bit RESET_ON_DOWN   = 1'b0,
  parameter int CNT_W           = 8
) (
  input  logic                    mac_aclk,
  input  logic                    sys_rst_n,
  input  logic [NUM_CH-1:0]       link_status_in,
  input  logic [NUM_CH-1:0]       sw_reset,
  input  logic                    cnt_clr,
  output logic [NUM_CH-1:0]       mac_reset,
  output logic [NUM_CH-1:0]       link_up,
  output logic [NUM_CH-1:0]       reset_done,
  output logic [NUM_CH*CNT_W-1:0] link_change_cnt
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [DW-1:0] DEB_LAST =
    DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST =
    HW'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LINK = 2'd1,
    RUN       = 2'd2
  } state_t;

  logic [NUM_CH-1:0][SYNC_STAGES-1:0] sync_q;
  logic [NUM_CH-1:0][SYNC_STAGES-1:0] sync_d;
  logic [NUM_CH-1:0]                  s;

  logic [NUM_CH-1:0][DW-1:0] deb_q;
  logic [NUM_CH-1:0][DW-1:0] deb_d;
  logic [NUM_CH-1:0]         link_q;
  logic [NUM_CH-1:0]         link_d;
  logic [NUM_CH-1:0]         ev;

  state_t                    state_q [NUM_CH];
  state_t                    state_d [NUM_CH];
  logic [NUM_CH-1:0][HW-1:0] hold_q;
  logic [NUM_CH-1:0][HW-1:0] hold_d;
  logic [NUM_CH-1:0]         mrst_q;
  logic [NUM_CH-1:0]         mrst_d;
  logic [NUM_CH-1:0]         done_q;
  logic [NUM_CH-1:0]         done_d;

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_d;

  // Shift raw link status through the synchroniser chain; bit 0 is first.
  always_comb begin
    sync_d = sync_q;
    s      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], link_status_in[i]};
      s[i]      = sync_q[i][SYNC_STAGES-1];
    end
  end

  // Synchroniser flops.
  always_ff @(posedge mac_aclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES.
  always_comb begin
    deb_d  = deb_q;
    link_d = link_q;
    ev     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (s[i] == link_q[i]) begin
        deb_d[i] = '0;
      end else if (deb_q[i] == DEB_LAST) begin
        deb_d[i]  = '0;
        link_d[i] = ~link_q[i];
        ev[i]     = 1'b1;
      end else begin
        deb_d[i] = deb_q[i] + DW'(1);
      end
    end
  end

  // Debounce counters and debounced link state.
  always_ff @(posedge mac_aclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      deb_q  <= '0;
      link_q <= '0;
    end else begin
      deb_q  <= deb_d;
      link_q <= link_d;
    end
  end

  // Sequencer next state: any link event or sw request restarts the hold.
  always_comb begin
    hold_d = hold_q;
    mrst_d = '0;
    done_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        HOLD: begin
          if (ev[i] || sw_reset[i]) begin
            hold_d[i] = '0;
          end else if (hold_q[i] == HOLD_LAST) begin
            if (RESET_ON_DOWN && !link_q[i]) begin
              state_d[i] = WAIT_LINK;
            end else begin
              state_d[i] = RUN;
            end
          end else begin
            hold_d[i] = hold_q[i] + HW'(1);
          end
        end
        WAIT_LINK: begin
          if (sw_reset[i] || (ev[i] && !link_q[i])) begin
            state_d[i] = HOLD;
            hold_d[i]  = '0;
          end
        end
        RUN: begin
          if (ev[i] || sw_reset[i]) begin
            state_d[i] = HOLD;
            hold_d[i]  = '0;
          end
        end
        default: begin
          state_d[i] = HOLD;
          hold_d[i]  = '0;
        end
      endcase
      mrst_d[i] = (state_d[i] != RUN);
      done_d[i] = (state_q[i] == HOLD) &&
                  (state_d[i] == RUN);
    end
  end

  // Sequencer state and its registered outputs.
  always_ff @(posedge mac_aclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= HOLD;
      end
      hold_q <= '0;
      mrst_q <= '1;
      done_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
      end
      hold_q <= hold_d;
      mrst_q <= mrst_d;
      done_q <= done_d;
    end
  end

  // Saturating edge counters; a clear that meets an event counts it.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cnt_clr) begin
        cnt_d[i] = ev[i] ? CNT_W'(1) : '0;
      end else if (ev[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Link-change counter flops.
  always_ff @(posedge mac_aclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mac_reset       = mrst_q;
  assign link_up         = link_q;
  assign reset_done      = done_q;
  assign link_change_cnt = cnt_q;

endmodule

// File: tb/tb_eth_link_reset_seq.sv
// tb_eth_link_reset_seq: mode-0 and mode-1 instances on shared stimulus,
// checked each cycle against a behavioural model plus directed literals.
module tb_eth_link_reset_seq;

  localparam int NCH = 4;
  localparam int SS  = 3;
  localparam int DB  = 16;
  localparam int HC  = 8;
  localparam int CW  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NCH-1:0] link_in = '0;
  logic [NCH-1:0] sw = '0;
  logic clr = 1'b0;

  logic [NCH-1:0] mr_a, lu_a, rd_a;
  logic [NCH-1:0] mr_b, lu_b, rd_b;
  logic [NCH*CW-1:0] cnt_a, cnt_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  eth_link_reset_seq #(
    .NUM_CH(NCH), .SYNC_STAGES(SS),
    .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HC),
    .RESET_ON_DOWN(1'b0), .CNT_W(CW)
  ) dut_a (
    .mac_aclk(clk), .sys_rst_n(rst_n),
    .link_status_in(link_in), .sw_reset(sw),
    .cnt_clr(clr), .mac_reset(mr_a),
    .link_up(lu_a), .reset_done(rd_a),
    .link_change_cnt(cnt_a)
  );

  eth_link_reset_seq #(
    .NUM_CH(NCH), .SYNC_STAGES(SS),
    .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HC),
    .RESET_ON_DOWN(1'b1), .CNT_W(CW)
  ) dut_b (
    .mac_aclk(clk), .sys_rst_n(rst_n),
    .link_status_in(link_in), .sw_reset(sw),
    .cnt_clr(clr), .mac_reset(mr_b),
    .link_up(lu_b), .reset_done(rd_b),
    .link_change_cnt(cnt_b)
  );

  // Model: input delay line, window of last DB synchronised samples,
  // edges since last trigger (event or sw), debounced level, counter.
  logic [SS-1:0] m_dly [NCH];
  logic [DB-1:0] m_win [NCH];
  bit            m_lu  [NCH];
  int            m_age [NCH];
  int            m_cnt [NCH];

  task automatic m_reset();
    for (int c = 0; c < NCH; c++) begin
      m_dly[c] = '0;
      m_win[c] = '0;
      m_lu[c]  = 1'b0;
      m_age[c] = 0;
      m_cnt[c] = 0;
    end
  endtask

  task automatic m_step();
    bit s_pre, e;
    for (int c = 0; c < NCH; c++) begin
      s_pre = m_dly[c][SS-1];
      m_win[c] = {m_win[c][DB-2:0], s_pre};
      e = m_lu[c] ? ~|m_win[c] : &m_win[c];
      if (e) m_lu[c] = !m_lu[c];
      if (clr) m_cnt[c] = e ? 1 : 0;
      else if (e && m_cnt[c] < 255) m_cnt[c]++;
      m_dly[c] = {m_dly[c][SS-2:0], link_in[c]};
      if (e || sw[c]) m_age[c] = 0;
      else if (m_age[c] < 1000000) m_age[c]++;
    end
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  initial begin
    logic [NCH-1:0] e_mr0, e_mr1, e_rd0, e_rd1, e_lu;
    logic [NCH*CW-1:0] e_cnt;
    forever begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        e_lu[c]  = m_lu[c];
        e_mr0[c] = m_age[c] < HC;
        e_mr1[c] = (m_age[c] < HC) || !m_lu[c];
        e_rd0[c] = m_age[c] == HC;
        e_rd1[c] = (m_age[c] == HC) && m_lu[c];
        e_cnt[c*CW +: CW] = CW'(m_cnt[c]);
      end
      chk("m_link_up_a", lu_a, e_lu);
      chk("m_link_up_b", lu_b, e_lu);
      chk("m_mac_reset_a", mr_a, e_mr0);
      chk("m_mac_reset_b", mr_b, e_mr1);
      chk("m_reset_done_a", rd_a, e_rd0);
      chk("m_reset_done_b", rd_b, e_rd1);
      chk("m_cnt_a", cnt_a, e_cnt);
      chk("m_cnt_b", cnt_b, e_cnt);
    end
  end

  initial begin
    wait_n(3);
    chk("rst_mr_a", mr_a, 4'hF);
    chk("rst_mr_b", mr_b, 4'hF);
    chk("rst_lu_a", lu_a, 4'h0);
    chk("rst_rd_a", rd_a, 4'h0);
    chk("rst_cnt_a", cnt_a, 32'h0);
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      wait_n(1);
      chk("p1_mr_a", mr_a, (k < 8) ? 4'hF : 4'h0);
      chk("p1_rd_a", rd_a, (k == 8) ? 4'hF : 4'h0);
      chk("p1_mr_b", mr_b, 4'hF);
      chk("p1_rd_b", rd_b, 4'h0);
    end
    wait_n(10);
    chk("p1_lu_a", lu_a, 4'h0);
    chk("p1_cnt_a", cnt_a, 32'h0);

    link_in[0] = 1'b1;
    wait_n(18);
    chk("p2_lu0_early", lu_a[0], 1'b0);
    wait_n(1);
    chk("p2_lu0_rise", lu_a[0], 1'b1);
    chk("p2_mr_a_asrt", mr_a, 4'h1);
    wait_n(7);
    chk("p2_mr0_held", mr_a[0], 1'b1);
    wait_n(1);
    chk("p2_mr0_rel", mr_a[0], 1'b0);
    chk("p2_rd_a", rd_a, 4'h1);
    chk("p2_mr0_b_rel", mr_b[0], 1'b0);
    chk("p2_cnt_a", cnt_a, 32'h0000_0001);
    wait_n(10);

    link_in[1] = 1'b1;
    wait_n(15);
    link_in[1] = 1'b0;
    wait_n(40);
    chk("p3_glitch_lu1", lu_a[1], 1'b0);
    chk("p3_glitch_cnt1", cnt_a[15:8], 8'd0);
    chk("p3_glitch_mr_a", mr_a, 4'h0);
    link_in[1] = 1'b1;
    wait_n(16);
    link_in[1] = 1'b0;
    wait_n(3);
    chk("p3_accept_lu1", lu_a[1], 1'b1);
    chk("p3_accept_cnt1", cnt_a[15:8], 8'd1);
    wait_n(60);

    sw[2] = 1'b1;
    wait_n(1);
    sw[2] = 1'b0;
    chk("p4_pulse_asrt", mr_a[2], 1'b1);
    wait_n(7);
    chk("p4_pulse_held", mr_a[2], 1'b1);
    wait_n(1);
    chk("p4_pulse_rel", mr_a[2], 1'b0);
    chk("p4_pulse_done", rd_a[2], 1'b1);
    wait_n(5);
    sw[2] = 1'b1;
    wait_n(5);
    sw[2] = 1'b0;
    wait_n(7);
    chk("p4_hold_held", mr_a[2], 1'b1);
    wait_n(1);
    chk("p4_hold_rel", mr_a[2], 1'b0);

    for (int k = 0; k < 1000; k++) begin
      wait_n(1);
      chk("p5_wait_mr_b3", mr_b[3], 1'b1);
      chk("p5_wait_rd_b3", rd_b[3], 1'b0);
    end
    link_in[3] = 1'b1;
    wait_n(19);
    chk("p5_lu_b3", lu_b[3], 1'b1);
    wait_n(7);
    chk("p5_mr_b3_held", mr_b[3], 1'b1);
    wait_n(1);
    chk("p5_mr_b3_rel", mr_b[3], 1'b0);
    chk("p5_rd_b3", rd_b[3], 1'b1);
    wait_n(10);
    link_in[3] = 1'b0;
    wait_n(18);
    chk("p5_mr_b3_up", mr_b[3], 1'b0);
    wait_n(1);
    chk("p5_mr_b3_reasrt", mr_b[3], 1'b1);
    chk("p5_lu_b3_down", lu_b[3], 1'b0);
    wait_n(100);
    chk("p5_mr_b3_kept", mr_b[3], 1'b1);
    chk("p5_mr_a3_rel", mr_a[3], 1'b0);

    for (int k = 0; k < 260; k++) begin
      link_in[3] = ~link_in[3];
      wait_n(20);
    end
    chk("p6_sat_a", cnt_a[31:24], 8'd255);
    chk("p6_sat_b", cnt_b[31:24], 8'd255);
    link_in[3] = 1'b1;
    wait_n(18);
    clr = 1'b1;
    wait_n(1);
    clr = 1'b0;
    chk("p6_clr_ev", cnt_a, 32'h0100_0000);
    wait_n(3);
    chk("p6_mid_hold", mr_a[3], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("p6_arst_mr_a", mr_a, 4'hF);
    chk("p6_arst_mr_b", mr_b, 4'hF);
    chk("p6_arst_lu_a", lu_a, 4'h0);
    chk("p6_arst_rd_a", rd_a, 4'h0);
    chk("p6_arst_cnt_a", cnt_a, 32'h0);
    chk("p6_arst_cnt_b", cnt_b, 32'h0);
    wait_n(2);
    rst_n = 1'b1;

    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(29) == 0) link_in[c] = ~link_in[c];
        sw[c] = ($urandom_range(49) == 0);
      end
      clr = ($urandom_range(199) == 0);
      wait_n(1);
    end
    sw = '0;
    clr = 1'b0;
    wait_n(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_link_reset_seq.md
Name: eth_link_reset_seq

Overview:
- Multi-channel, parametrised successor to the per-MAC link-driven reset generator.
- Single clock domain for NUM_CH MAC/PHY channels. Per channel: synchronise raw link status, debounce it, run a reset sequencer that drives a per-channel MAC reset.
- Adds a software reset request, a selectable hold-while-link-down mode, reset-done pulses and per-channel saturating link-change counters.
- Sits between the PHY in-band status decoders and the MAC cores.

Parameters:
- NUM_CH, 4, number of independent channels (>=1).
- SYNC_STAGES, 3, synchroniser flops on each link_status_in bit (>=2).
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised level must differ from link_up before it is accepted (>=1).
- HOLD_CYCLES, 8, mac_reset assertion length in cycles (>=1).
- RESET_ON_DOWN, 0, mode. 0: pulse reset on every debounced link edge. 1: additionally hold reset while the debounced link is down.
- CNT_W, 8, width of each link-change counter.

Ports:
- mac_aclk  in  1  sole clock, all logic rising-edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- link_status_in  in  NUM_CH  raw, asynchronous PHY link status per channel. 1 = up.
- sw_reset  in  NUM_CH  synchronous per-channel reset request, level-sensitive.
- cnt_clr  in  1  synchronous clear of all link-change counters.
- mac_reset  out  NUM_CH  registered, active-high MAC reset per channel.
- link_up  out  NUM_CH  registered, debounced link status.
- reset_done  out  NUM_CH  one-cycle pulse when a channel leaves reset.
- link_change_cnt  out  NUM_CH*CNT_W  per-channel debounced-edge counters. Channel i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset (sys_rst_n=0, asynchronous), all values forced immediately:
  - mac_reset = all 1; link_up = 0; reset_done = 0; link_change_cnt = 0.
  - Synchroniser flops = 0; debounce counters = 0; every channel in HOLD with hold_cnt = 0.
- Channels are fully independent and share only mac_aclk, sys_rst_n and cnt_clr.
- Synchroniser: s[i] is the last of SYNC_STAGES flops. Latency from a sampled input edge to s is SYNC_STAGES cycles.
- Debounce:
  - deb_cnt is $clog2(DEBOUNCE_CYCLES+1) bits wide.
  - If s == link_up, deb_cnt clears.
  - Otherwise deb_cnt increments. On the edge where s != link_up and deb_cnt == DEBOUNCE_CYCLES-1, link_up toggles, deb_cnt clears, and combinational event ev[i] = 1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles is ignored. Total input-to-link_up latency is SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- Per-channel FSM. States are HOLD, WAIT_LINK and RUN. hold_cnt is $clog2(HOLD_CYCLES) bits wide, minimum 1.
  - HOLD:
    - If ev or sw_reset: hold_cnt <= 0 and stay in HOLD.
    - Else, if hold_cnt == HOLD_CYCLES-1: go to WAIT_LINK when RESET_ON_DOWN=1 and link_up=0; otherwise go to RUN.
    - Else hold_cnt++.
  - WAIT_LINK:
    - sw_reset, or ev raising link_up: go to HOLD with hold_cnt <= 0.
    - Otherwise stay. This state can last indefinitely.
  - RUN:
    - ev (either edge) or sw_reset: go to HOLD with hold_cnt <= 0.
- mac_reset[i] is registered as (next_state != RUN). It asserts on the same edge that link_up changes or that sw_reset is sampled.
  - From RUN, mac_reset stays high for exactly HOLD_CYCLES cycles.
  - With sw_reset held, mac_reset releases HOLD_CYCLES edges after the last edge that sampled sw_reset=1.
- reset_done[i] is registered and equals 1 only on the edge where the state goes HOLD->RUN. Never asserted for HOLD->WAIT_LINK.
- link_change_cnt:
  - Increments on ev and saturates at 2^CNT_W-1.
  - cnt_clr alone loads 0.
  - cnt_clr together with ev loads 1.
- Asynchronous reset mid-sequence aborts everything and restarts from the reset values.
- After reset release: mac_reset is 1 for HOLD_CYCLES cycles. It then goes to 0 (mode 0), or stays 1 in WAIT_LINK (mode 1 with link down).

Test Plan:
- 1. Defaults, all links 0, release sys_rst_n:
  - mac_reset = 4'hF for 8 cycles, then 4'h0.
  - reset_done = 4'hF for exactly one cycle, on the 8th edge.
  - link_up = 0; counters = 0.
- 2. Raise link_status_in[0] and hold:
  - link_up[0] rises 19 cycles later (3+16).
  - mac_reset[0] is 1 for exactly 8 cycles from that edge.
  - link_change_cnt[0] = 1; channels 1-3 unchanged.
- 3. Glitch link_status_in[1] high for 15 cycles: no link_up, mac_reset or counter change. Repeat with 16 cycles: link_up[1] toggles once.
- 4. sw_reset[2]:
  - One-cycle pulse in RUN: mac_reset[2] high for 8 cycles, reset_done[2] pulse.
  - Held for 5 cycles: mac_reset[2] releases 8 edges after the last sampled sw_reset edge.
- 5. RESET_ON_DOWN=1, link 0:
  - mac_reset stays 1 for 1000 cycles with no reset_done.
  - Raise the link: mac_reset releases 8 cycles after link_up rises.
  - Drop the link: reset reasserts and is held.
- 6. Counters and reset:
  - Toggle the ch3 link 260 times: counter saturates at 255.
  - cnt_clr coincident with an event: counter reads 1.
  - Assert sys_rst_n=0 mid-HOLD: all outputs return immediately to their reset values.
